// File: rtl/cfg_pkg.sv
// Shared types and constants for the config frame dispatcher.
package cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE
  } state_t;

  localparam logic [1:0] FLT_NONE = 2'd0;
  localparam logic [1:0] FLT_PAR  = 2'd1;
  localparam logic [1:0] FLT_TGT  = 2'd2;
  localparam logic [1:0] FLT_TMO  = 2'd3;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Width of the target-select field taken from the top of the address.
  function automatic int unsigned tgt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cfg_frame_fifo.sv
// Synchronous frame buffer; combinational head read, push allowed when full if popping.
module cfg_frame_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cfg_frame_dispatch.sv
// Buffers UART config frames, checks parity, decodes target and issues
// one-hot valid/ack writes with timeout and fault reporting.
module cfg_frame_dispatch
  import cfg_pkg::*;
#(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned N_TGT       = 2,
  parameter int unsigned PARITY_MODE = 1,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W+DATA_W:0]   frame,
  input  logic                     frame_valid,
  input  logic [N_TGT-1:0]         ack,
  output logic [ADDR_W-1:0]        address,
  output logic [DATA_W-1:0]        data,
  output logic [N_TGT-1:0]         valid,
  output logic                     busy,
  output logic                     fault,
  output logic [1:0]               fault_code,
  output logic [7:0]               fault_cnt
);

  localparam int unsigned FW    = 1 + ADDR_W + DATA_W;
  localparam int unsigned TGT_W = tgt_width(N_TGT);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TGT_W:0] N_TGT_V = (TGT_W+1)'(N_TGT);
  localparam logic [TMR_W-1:0] TMO_V = TMR_W'(TIMEOUT);

  state_t            state;
  logic [FW-1:0]     hold;
  logic [TMR_W-1:0]  timer;
  logic [FW-1:0]     fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              overflow;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic [TGT_W-1:0]  tgt;
  logic              parity_ok;
  logic              tgt_ok;
  logic              ack_hit;
  logic [1:0]        fsm_code;
  logic              fsm_flt;
  logic [1:0]        n_new;
  logic [8:0]        cnt_sum;

  assign pop      = (state == ST_IDLE) & ~fifo_empty;
  assign overflow = frame_valid & fifo_full & ~pop;
  assign busy     = (state != ST_IDLE) | ~fifo_empty;

  cfg_frame_fifo #(
    .WIDTH(FW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (frame_valid),
    .pop  (pop),
    .din  (frame),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign hold_addr = hold[ADDR_W+DATA_W-1 -: ADDR_W];
  assign hold_data = hold[DATA_W-1:0];
  assign tgt       = hold_addr[ADDR_W-1 -: TGT_W];
  assign tgt_ok    = ({1'b0, tgt} < N_TGT_V);
  // valid is one-hot on the selected target, so masking ack with it drops foreign acks.
  assign ack_hit   = |(ack & valid);

  // Parity check over the whole held frame.
  always_comb begin
    parity_ok = 1'b1;
    if (PARITY_MODE == PAR_EVEN)     parity_ok = ~(^hold);
    else if (PARITY_MODE == PAR_ODD) parity_ok = ^hold;
  end

  // Fault raised by the FSM on this edge, if any.
  always_comb begin
    fsm_code = FLT_NONE;
    if (state == ST_CHECK) begin
      if (!parity_ok)   fsm_code = FLT_PAR;
      else if (!tgt_ok) fsm_code = FLT_TGT;
    end else if (state == ST_ISSUE && !ack_hit && timer == TMO_V) begin
      fsm_code = FLT_TMO;
    end
  end

  assign fsm_flt = (fsm_code != FLT_NONE);
  assign n_new   = {1'b0, fsm_flt} + {1'b0, overflow};
  assign cnt_sum = {1'b0, fault_cnt} + 9'(n_new);

  // Dispatch FSM with registered address/data/valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      hold    <= '0;
      timer   <= '0;
      address <= '0;
      data    <= '0;
      valid   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            hold  <= fifo_dout;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!fsm_flt) begin
            address <= hold_addr;
            data    <= hold_data;
            valid   <= N_TGT'(1) << tgt;
            timer   <= '0;
            state   <= ST_ISSUE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (ack_hit || timer == TMO_V) begin
            valid <= '0;
            state <= ST_IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Fault pulse, last code and saturating count; FSM code takes priority over overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault      <= 1'b0;
      fault_code <= FLT_NONE;
      fault_cnt  <= '0;
    end else begin
      fault <= fsm_flt | overflow;
      if (fsm_flt)       fault_code <= fsm_code;
      else if (overflow) fault_code <= FLT_TMO;
      fault_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    end
  end

endmodule

// File: tb/tb_cfg_frame_dispatch.sv
// Directed and randomized bench for cfg_frame_dispatch (N_TGT=3, TIMEOUT=8, even parity).
module tb_cfg_frame_dispatch;

  localparam int NT  = 3;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] frame;
  logic       frame_valid;
  logic [2:0] ack;
  logic [3:0] address;
  logic [3:0] data;
  logic [2:0] valid;
  logic       busy;
  logic       fault;
  logic [1:0] fault_code;
  logic [7:0] fault_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  int exp_code = 0;

  cfg_frame_dispatch #(
    .ADDR_W(4), .DATA_W(4), .N_TGT(NT), .PARITY_MODE(1), .FIFO_DEPTH(4), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .frame(frame), .frame_valid(frame_valid), .ack(ack),
    .address(address), .data(data), .valid(valid), .busy(busy), .fault(fault),
    .fault_code(fault_code), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame with correct even parity.
  function automatic logic [8:0] mk(input logic [3:0] a, input logic [3:0] d);
    return {^{a, d}, a, d};
  endfunction

  function automatic int outcome(input logic [8:0] f);
    if (^f) return 1;
    if (int'(f[7:6]) >= NT) return 2;
    return 0;
  endfunction

  task automatic note_fault(input int code, input int n);
    exp_cnt  = (exp_cnt + n > 255) ? 255 : exp_cnt + n;
    exp_code = code;
  endtask

  task automatic send(input logic [8:0] f);
    frame = f;
    frame_valid = 1'b1;
    tick;
    frame_valid = 1'b0;
  endtask

  // One frame into an idle dispatcher; ack asserted in the d-th valid-high cycle (0-based).
  task automatic run_frame(input logic [8:0] f, input int d);
    int code;
    int high;
    int exp_high;
    logic [2:0] sel;
    code = outcome(f);
    send(f);
    chk("lat_t0_valid", valid, 0);
    tick;
    chk("lat_t1_valid", valid, 0);
    tick;
    if (code != 0) begin
      note_fault(code, 1);
      chk("rej_valid", valid, 0);
      chk("rej_fault", fault, 1);
      chk("rej_code", fault_code, exp_code);
      chk("rej_cnt", fault_cnt, exp_cnt);
      chk("rej_busy", busy, 0);
      tick;
      chk("rej_pulse_end", fault, 0);
    end else begin
      sel = 3'b001 << f[7:6];
      chk("disp_fault", fault, 0);
      high = 0;
      while (valid !== 3'b000 && high < 20) begin
        chk("issue_valid", valid, sel);
        chk("issue_addr", address, f[7:4]);
        chk("issue_data", data, f[3:0]);
        ack = (3'($urandom) & ~sel) | ((high == d) ? sel : 3'b000);
        high++;
        tick;
      end
      ack = 3'b000;
      exp_high = (d <= TMO) ? d + 1 : TMO + 1;
      chk("valid_cycles", high, exp_high);
      if (d > TMO) note_fault(3, 1);
      chk("end_fault", fault, (d > TMO) ? 1 : 0);
      chk("end_code", fault_code, exp_code);
      chk("end_cnt", fault_cnt, exp_cnt);
      chk("end_busy", busy, 0);
      chk("hold_addr", address, f[7:4]);
      tick;
      chk("end_pulse", fault, 0);
    end
  endtask

  // Wait (bounded) for the next dispatch, check it, ack immediately.
  task automatic serve(input logic [8:0] f);
    int n;
    logic [2:0] sel;
    sel = 3'b001 << f[7:6];
    n = 0;
    while (valid === 3'b000 && n < 20) begin
      tick;
      n++;
    end
    chk("serve_valid", valid, sel);
    chk("serve_addr", address, f[7:4]);
    chk("serve_data", data, f[3:0]);
    ack = sel;
    tick;
    ack = 3'b000;
    chk("serve_drop", valid, 0);
  endtask

  initial begin
    logic [8:0] f;
    int d;
    rst = 1'b1;
    frame = '0;
    frame_valid = 1'b0;
    ack = '0;
    tick;
    tick;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_code", fault_code, 0);
    chk("rst_cnt", fault_cnt, 0);
    chk("rst_addr", address, 0);
    chk("rst_data", data, 0);
    rst = 1'b0;
    tick;

    // Basic dispatch, parity error, bad target, timeout, ack on last cycle.
    run_frame(9'b0_0011_0101, 2);
    run_frame(9'b1_0011_0101, 0);
    run_frame(9'b1_1100_0001, 0);
    run_frame(9'b0_0101_0011, 100);
    run_frame(mk(4'h6, 4'hA), TMO);

    // Six frames back to back while the first is unacked: sixth is dropped.
    for (int i = 0; i < 6; i++) begin
      frame = mk(4'(i + 1), 4'(i + 8));
      frame_valid = 1'b1;
      tick;
      if (i == 5) note_fault(3, 1);
      chk("ovf_fault", fault, (i == 5) ? 1 : 0);
    end
    frame_valid = 1'b0;
    chk("ovf_code", fault_code, exp_code);
    chk("ovf_cnt", fault_cnt, exp_cnt);
    for (int i = 0; i < 5; i++) serve(mk(4'(i + 1), 4'(i + 8)));
    chk("ovf_busy", busy, 0);

    // Overflow drop on the same edge as a timeout: one pulse, count +2.
    tick;
    for (int k = 0; k < 12; k++) begin
      frame = mk(4'(k + 1), 4'(15 - k));
      frame_valid = (k <= 4 || k == 11);
      tick;
      if (k == 10) chk("dual_valid_hold", valid, 3'b001);
    end
    frame_valid = 1'b0;
    note_fault(3, 2);
    chk("dual_valid", valid, 0);
    chk("dual_fault", fault, 1);
    chk("dual_code", fault_code, exp_code);
    chk("dual_cnt", fault_cnt, exp_cnt);
    tick;
    chk("dual_pulse_end", fault, 0);
    for (int k = 1; k <= 4; k++) serve(mk(4'(k + 1), 4'(15 - k)));
    chk("dual_busy", busy, 0);

    // Reset while a request is outstanding.
    tick;
    send(mk(4'h6, 4'h9));
    tick;
    tick;
    chk("prerst_valid", valid, 3'b010);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_cnt = 0;
    exp_code = 0;
    chk("midrst_valid", valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cnt", fault_cnt, 0);
    chk("midrst_code", fault_code, 0);
    run_frame(mk(4'h2, 4'hC), 0);

    // Randomized frames and ack delays.
    for (int i = 0; i < 40; i++) begin
      f = 9'($urandom);
      d = $urandom_range(0, 11);
      run_frame(f, d);
    end

    // Drive the fault counter into saturation.
    for (int i = 0; i < 260; i++) begin
      f = mk(4'h2, 4'h7);
      f[8] = ~f[8];
      run_frame(f, 0);
    end
    chk("sat_cnt", fault_cnt, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
